// File: rtl/twos_to_sign_mag.sv
// Bit-serial two's-complement to sign-magnitude decoder, LSB first.
// Each bit is copied until the first 1 is seen; later bits are inverted when the word is negative.
module twos_to_sign_mag #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             busy
);

    localparam int unsigned        CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   mag_q,   mag_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               seen_q,  seen_d;
    logic               sign_q,  sign_d;
    logic               mag_bit;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            mag_q   <= '0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            sign_q  <= sign_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        sign_d  = sign_q;
        mag_bit = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    sign_d  = in_data[WIDTH-1];
                    mag_d   = '0;
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                // Magnitude fills from the top so bit i lands at index i after WIDTH shifts
                mag_bit = (sign_q && seen_q) ? ~shift_q[0] : shift_q[0];
                seen_d  = seen_q | shift_q[0];
                mag_d   = {mag_bit, mag_q[WIDTH-1:1]};
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready is masked by rst because the state already reads IDLE during reset
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sign  = sign_q;
    assign out_mag   = mag_q;

endmodule

// File: tb/tb_twos_to_sign_mag.sv
// Self-checking bench for twos_to_sign_mag at WIDTH=4 and WIDTH=8.
module tb_twos_to_sign_mag;

    logic clk = 1'b0;
    logic rst;

    logic       iv4, ir4, ov4, or4, os4, busy4;
    logic [3:0] id4, om4;
    logic       iv8, ir8, ov8, or8, os8, busy8;
    logic [7:0] id8, om8;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    twos_to_sign_mag #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_valid(ov4), .out_ready(or4),
        .out_sign(os4), .out_mag(om4), .busy(busy4)
    );

    twos_to_sign_mag #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .out_valid(ov8), .out_ready(or8),
        .out_sign(os8), .out_mag(om8), .busy(busy8)
    );

    // Reference: magnitude of the signed value, returned as {sign, mag[7:0]}
    function automatic logic [8:0] model(input int w, input logic [7:0] d);
        int u, s, m;
        u = int'(d) & ((1 << w) - 1);
        s = (u >> (w - 1)) & 1;
        m = (s == 1) ? (((1 << w) - u) & ((1 << w) - 1)) : u;
        return {1'(s), 8'(m)};
    endfunction

    function automatic logic [8:0] result(input int w);
        return (w == 4) ? {os4, 4'b0000, om4} : {os8, om8};
    endfunction
    function automatic logic get_ready(input int w);
        return (w == 4) ? ir4 : ir8;
    endfunction
    function automatic logic get_valid(input int w);
        return (w == 4) ? ov4 : ov8;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 4) ? busy4 : busy8;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int w, input logic v, input logic [7:0] d);
        if (w == 4) begin iv4 = v; id4 = d[3:0]; end
        else        begin iv8 = v; id8 = d;      end
    endtask

    task automatic set_ordy(input int w, input logic r);
        if (w == 4) or4 = r; else or8 = r;
    endtask

    // One full transaction: accept, check latency, optional stall, release
    task automatic do_word(input int w, input logic [7:0] d, input int stall);
        logic [8:0] exp;
        string      t;
        exp = model(w, d);
        t   = $sformatf("w%0d_d%0h", w, d);
        @(negedge clk);
        check({t, "_ready_idle"}, 32'(get_ready(w)), 32'd1);
        set_in(w, 1'b1, d);
        set_ordy(w, stall == 0);
        @(negedge clk);
        set_in(w, 1'b0, 8'h00);
        check({t, "_busy"}, {30'd0, get_ready(w), get_busy(w)}, 32'b01);
        for (int k = 1; k <= w; k++) begin
            @(negedge clk);
            if (k < w) begin
                check({t, "_early_valid"}, 32'(get_valid(w)), 32'd0);
            end else begin
                check({t, "_valid_at_w"}, 32'(get_valid(w)), 32'd1);
                check({t, "_result"}, 32'(result(w)), 32'(exp));
            end
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({t, "_stall_hold"}, {22'd0, get_valid(w), get_ready(w), result(w)},
                  {22'd0, 1'b1, 1'b0, exp});
        end
        set_ordy(w, 1'b1);
        @(negedge clk);
        check({t, "_back_idle"}, {29'd0, get_valid(w), get_ready(w), get_busy(w)}, 32'b010);
    endtask

    initial begin
        int         acc[$];
        logic [3:0] pending;
        logic       got_acc;

        rst = 1'b1;
        set_in(4, 1'b0, 8'h00);
        set_in(8, 1'b0, 8'h00);
        or4 = 1'b1;
        or8 = 1'b1;
        #3;
        check("reset_outs4", {25'd0, ir4, ov4, busy4, os4, om4}, 32'd0);
        check("reset_outs8", {21'd0, ir8, ov8, busy8, os8, om8}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_reset", {30'd0, ir4, ir8}, 32'b11);

        // Full WIDTH=4 sweep
        for (int v = 0; v < 16; v++) do_word(4, 8'(v), 0);

        // WIDTH=8 corners then random words
        do_word(8, 8'h80, 0);
        do_word(8, 8'h00, 0);
        do_word(8, 8'hFF, 0);
        do_word(8, 8'h7F, 0);
        for (int i = 0; i < 12; i++) do_word(8, 8'($urandom), 0);

        // Backpressure on 1101
        do_word(4, 8'h0D, 10);
        do_word(8, 8'($urandom), 5);

        // Back-to-back accepts with in_valid and out_ready held high
        got_acc = 1'b0;
        pending = '0;
        @(negedge clk);
        id4 = 4'($urandom);
        iv4 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (got_acc) begin
                id4 = 4'($urandom);
                got_acc = 1'b0;
            end
            if (ov4) check($sformatf("b2b_result_%0d", c), 32'(result(4)), 32'(model(4, 8'(pending))));
            if (ir4) begin
                acc.push_back(c);
                pending = id4;
                got_acc = 1'b1;
            end
            @(negedge clk);
        end
        iv4 = 1'b0;
        check("b2b_accept_count", 32'(acc.size()), 32'd7);
        for (int i = 1; i < acc.size(); i++)
            check($sformatf("b2b_spacing_%0d", i), 32'(acc[i] - acc[i-1]), 32'd6);
        @(negedge clk);
        @(negedge clk);

        // Reset two cycles into a conversion of 1010
        @(negedge clk);
        set_in(4, 1'b1, 8'h0A);
        @(negedge clk);
        set_in(4, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_outs", {25'd0, ir4, ov4, busy4, os4, om4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset_ready", 32'(ir4), 32'd1);
        do_word(4, 8'h05, 0);

        // Random WIDTH=4 words with random short stalls
        for (int i = 0; i < 10; i++) do_word(4, 8'($urandom), int'($urandom_range(0, 3)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
